// File: rtl/secventiator_cursa.sv
// Run sequencer for the line-follower car: start countdown, debounced
// finish-line detection, lap counting per circuit mode, soft-start ramp
// on the duty factors and direction gating outside the running states.
module secventiator_cursa #(
   parameter logic [15:0] DEBOUNCE_CYC  = 16'd50000,
   parameter logic [23:0] HOLDOFF_CYC   = 24'd10000000,
   parameter logic [27:0] COUNTDOWN_CYC = 28'd150000000,
   parameter logic [15:0] RAMP_DIV      = 16'd25000,
   parameter logic [11:0] RAMP_INC      = 12'h010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        senzor_1,
   input  logic        senzor_5,
   input  logic [1:0]  circuit,
   input  logic [1:0]  directie_in_A,
   input  logic [1:0]  directie_in_B,
   input  logic [11:0] factor_dc_in_A,
   input  logic [11:0] factor_dc_in_B,
   output logic [1:0]  directie_driverA,
   output logic [1:0]  directie_driverB,
   output logic [11:0] factor_dc_driverA,
   output logic [11:0] factor_dc_driverB,
   output logic [7:0]  count_ture,
   output logic        motor_en,
   output logic        cursa_gata,
   output logic [2:0]  stare
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_RUN       = 3'd2,
      ST_HOLDOFF   = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   // Lap target for a circuit mode; zero means no limit (or off).
   function automatic logic [7:0] lap_target(input logic [1:0] mode);
      logic [7:0] t;
      case (mode)
         2'b01:   t = 8'd1;
         2'b10:   t = 8'd10;
         default: t = 8'd0;
      endcase
      return t;
   endfunction

   // Smaller of two duty factors.
   function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
      logic [11:0] m;
      if (a < b) m = a;
      else       m = b;
      return m;
   endfunction

   logic s1_meta_q, s1_sync_q, s5_meta_q, s5_sync_q;
   logic start_meta_q, start_sync_q, start_prev_q;
   logic armed_q, armed_d, linie_q, linie_d;
   logic [15:0] deb_cnt_q, deb_cnt_d;
   state_t state_q, state_d;
   logic [7:0]  count_q, count_d;
   logic [27:0] timer_q, timer_d;
   logic [11:0] ramp_q, ramp_d;
   logic [15:0] ramp_div_q, ramp_div_d;
   logic [1:0]  dir_a_q, dir_b_q;
   logic [11:0] fac_a_q, fac_b_q;
   logic        motor_en_q, gata_q;

   logic start_edge_s, both_hi_s, both_lo_s, agree_s;
   logic running_s, run_next_s;
   logic [7:0]  target_s, count_inc_s;
   logic [12:0] ramp_sum_s;
   logic [11:0] ramp_sat_s;

   assign start_edge_s = start_sync_q & ~start_prev_q;
   assign both_hi_s    = s1_sync_q & s5_sync_q;
   assign both_lo_s    = ~s1_sync_q & ~s5_sync_q;
   assign agree_s      = armed_q ? both_hi_s : both_lo_s;
   assign running_s    = (state_q == ST_RUN) || (state_q == ST_HOLDOFF);
   assign run_next_s   = (state_d == ST_RUN) || (state_d == ST_HOLDOFF);
   assign target_s     = lap_target(circuit);
   assign count_inc_s  = (count_q == 8'hFF) ? 8'hFF : (count_q + 8'd1);
   assign ramp_sum_s   = {1'b0, ramp_q} + {1'b0, RAMP_INC};
   assign ramp_sat_s   = ramp_sum_s[12] ? 12'hFFF : ramp_sum_s[11:0];

   // Two-flop synchronizers for sensors and start, plus start edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_meta_q    <= 1'b0;
         s1_sync_q    <= 1'b0;
         s5_meta_q    <= 1'b0;
         s5_sync_q    <= 1'b0;
         start_meta_q <= 1'b0;
         start_sync_q <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         s1_meta_q    <= senzor_1;
         s1_sync_q    <= s1_meta_q;
         s5_meta_q    <= senzor_5;
         s5_sync_q    <= s5_meta_q;
         start_meta_q <= start;
         start_sync_q <= start_meta_q;
         start_prev_q <= start_sync_q;
      end
   end

   // Finish detector: armed waits for a stable black pair, disarmed for a stable white pair.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      armed_d   = armed_q;
      linie_d   = 1'b0;
      if (!agree_s) begin
         deb_cnt_d = 16'd0;
      end else if (deb_cnt_q == (DEBOUNCE_CYC - 16'd1)) begin
         deb_cnt_d = 16'd0;
         armed_d   = ~armed_q;
         linie_d   = armed_q;
      end else begin
         deb_cnt_d = deb_cnt_q + 16'd1;
      end
   end

   // Detector state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt_q <= 16'd0;
         armed_q   <= 1'b1;
         linie_q   <= 1'b0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         armed_q   <= armed_d;
         linie_q   <= linie_d;
      end
   end

   // Run sequencing: next state, lap count, shared timer and ramp.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      timer_d    = timer_q;
      ramp_d     = ramp_q;
      ramp_div_d = ramp_div_q;
      if (running_s) begin
         if (ramp_div_q == (RAMP_DIV - 16'd1)) begin
            ramp_div_d = 16'd0;
            ramp_d     = ramp_sat_s;
         end else begin
            ramp_div_d = ramp_div_q + 16'd1;
         end
      end else begin
         ramp_div_d = ramp_div_q;
      end
      if (circuit == 2'b00) begin
         // Abort wins over everything, including a simultaneous lap.
         state_d = ST_IDLE;
         count_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_edge_s) begin
                  state_d = ST_COUNTDOWN;
                  count_d = 8'd0;
                  timer_d = COUNTDOWN_CYC - 28'd1;
               end else begin
                  state_d = state_q;
               end
            end
            ST_COUNTDOWN: begin
               if (timer_q == 28'd0) begin
                  state_d    = ST_RUN;
                  ramp_d     = 12'h000;
                  ramp_div_d = 16'd0;
               end else begin
                  timer_d = timer_q - 28'd1;
               end
            end
            ST_RUN: begin
               if (linie_q) begin
                  count_d = count_inc_s;
                  if ((target_s != 8'd0) && (count_inc_s >= target_s)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_HOLDOFF;
                     timer_d = {4'd0, HOLDOFF_CYC} - 28'd1;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_HOLDOFF: begin
               if (timer_q == 28'd0) begin
                  state_d = ST_RUN;
               end else begin
                  timer_d = timer_q - 28'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= 8'd0;
         timer_q    <= 28'd0;
         ramp_q     <= 12'h000;
         ramp_div_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         ramp_q     <= ramp_d;
         ramp_div_q <= ramp_div_d;
      end
   end

   // Driver outputs follow the next state so they line up with stare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_a_q    <= 2'b00;
         dir_b_q    <= 2'b00;
         fac_a_q    <= 12'h000;
         fac_b_q    <= 12'h000;
         motor_en_q <= 1'b0;
         gata_q     <= 1'b0;
      end else begin
         dir_a_q    <= run_next_s ? directie_in_A : 2'b00;
         dir_b_q    <= run_next_s ? directie_in_B : 2'b00;
         fac_a_q    <= run_next_s ? min12(factor_dc_in_A, ramp_d) : 12'h000;
         fac_b_q    <= run_next_s ? min12(factor_dc_in_B, ramp_d) : 12'h000;
         motor_en_q <= run_next_s;
         gata_q     <= (state_d == ST_DONE);
      end
   end

   assign directie_driverA  = dir_a_q;
   assign directie_driverB  = dir_b_q;
   assign factor_dc_driverA = fac_a_q;
   assign factor_dc_driverB = fac_b_q;
   assign count_ture        = count_q;
   assign motor_en          = motor_en_q;
   assign cursa_gata        = gata_q;
   assign stare             = state_q;

endmodule
